cache_line_refill: RTL and testbench

Miss handler sitting between the direct-mapped, 4-column write-back cache and the burst memory controller. When the cache reports a miss, this block writes back the dirty victim line if there is one, then reads the missing line as a 4-word burst. It returns the line to the cache as a single whole-line fill carrying valid=1 and dirty=0. It is the memory-side end of the cache's tag/valid/dirty line protocol.

---
 rtl/cache_line_refill.sv | 203 ++++++++++++++++++++
 tb/tb_cache_line_refill.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_line_refill.sv
// cache_line_refill: miss handler between a direct-mapped 4-column write-back cache and a
// burst memory controller. On a miss it writes back the dirty victim line (if any), reads the
// missing line as a 4-beat burst and hands it to the cache as one whole-line fill.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   start, miss_address         miss request (sampled only when idle) and the missing address
//   victim_dirty/tag/data       victim line at the miss index, captured at start
//   busy, done                  activity flag; one-cycle completion pulse
//   fill_write/tag/line_ix/data whole-line fill to the cache (valid=1, dirty=0 implied)
//   mem_cmd_*                   burst command channel (valid/ready, write flag, line address)
//   mem_wdata*                  write beat channel (valid/ready)
//   mem_rdata*                  read beat strobe, no backpressure
module cache_line_refill #(
    parameter int LINE_IX_BITWIDTH = 8,
    localparam int TAG_BITWIDTH = 32 - LINE_IX_BITWIDTH - 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [31:0]                 miss_address,
    input  logic                        victim_dirty,
    input  logic [TAG_BITWIDTH-1:0]     victim_tag,
    input  logic [127:0]                victim_data,
    output logic                        busy,
    output logic                        done,
    output logic                        fill_write,
    output logic [TAG_BITWIDTH-1:0]     fill_tag,
    output logic [LINE_IX_BITWIDTH-1:0] fill_line_ix,
    output logic [127:0]                fill_data,
    output logic                        mem_cmd_valid,
    output logic                        mem_cmd_write,
    output logic [31:0]                 mem_cmd_address,
    input  logic                        mem_cmd_ready,
    output logic [31:0]                 mem_wdata,
    output logic                        mem_wdata_valid,
    input  logic                        mem_wdata_ready,
    input  logic [31:0]                 mem_rdata,
    input  logic                        mem_rdata_valid
);

    typedef enum logic [2:0] {
        StIdle,
        StWbCmd,
        StWbData,
        StRdCmd,
        StRdData,
        StFill
    } state_e;

    state_e state_q, state_d;

    logic [1:0]                beat_q;
    // Line address of the miss (miss_address[31:4]); low byte-offset bits are never needed.
    logic [27:0]               line_addr_q;
    logic [TAG_BITWIDTH-1:0]   victim_tag_q;
    logic [127:0]              victim_data_q;
    // Columns 0..2 of the incoming line; column 3 goes straight into fill_data_q.
    logic [95:0]               line_q;
    logic [127:0]              fill_data_q;
    logic [TAG_BITWIDTH-1:0]   fill_tag_q;
    logic [LINE_IX_BITWIDTH-1:0] fill_ix_q;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = victim_dirty ? StWbCmd : StRdCmd;
                end
            end
            StWbCmd: begin
                if (mem_cmd_ready) begin
                    state_d = StWbData;
                end
            end
            StWbData: begin
                if (mem_wdata_ready && beat_q == 2'd3) begin
                    state_d = StRdCmd;
                end
            end
            StRdCmd: begin
                if (mem_cmd_ready) begin
                    state_d = StRdData;
                end
            end
            StRdData: begin
                if (mem_rdata_valid && beat_q == 2'd3) begin
                    state_d = StFill;
                end
            end
            StFill: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Datapath: request capture, beat counter, line assembly and fill holding registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_q        <= 2'd0;
            line_addr_q   <= '0;
            victim_tag_q  <= '0;
            victim_data_q <= '0;
            line_q        <= '0;
            fill_data_q   <= '0;
            fill_tag_q    <= '0;
            fill_ix_q     <= '0;
        end else begin
            if (state_q == StIdle && start) begin
                line_addr_q   <= miss_address[31:4];
                victim_tag_q  <= victim_tag;
                victim_data_q <= victim_data;
                beat_q        <= 2'd0;
            end
            // Counter wraps 3->0 naturally on the last accepted write beat.
            if (state_q == StWbData && mem_wdata_ready) begin
                beat_q <= beat_q + 2'd1;
            end
            if (state_q == StRdCmd && mem_cmd_ready) begin
                beat_q <= 2'd0;
            end
            if (state_q == StRdData && mem_rdata_valid) begin
                beat_q <= beat_q + 2'd1;
                unique case (beat_q)
                    2'd0: line_q[31:0]  <= mem_rdata;
                    2'd1: line_q[63:32] <= mem_rdata;
                    2'd2: line_q[95:64] <= mem_rdata;
                    2'd3: begin
                        // Fill outputs load only here so they hold between fills.
                        fill_data_q <= {mem_rdata, line_q};
                        fill_tag_q  <= line_addr_q[27:LINE_IX_BITWIDTH];
                        fill_ix_q   <= line_addr_q[LINE_IX_BITWIDTH-1:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Output decode from registered state only
    always_comb begin
        busy            = 1'b0;
        done            = 1'b0;
        fill_write      = 1'b0;
        mem_cmd_valid   = 1'b0;
        mem_cmd_write   = 1'b0;
        mem_cmd_address = 32'd0;
        mem_wdata_valid = 1'b0;
        mem_wdata       = 32'd0;
        fill_data       = fill_data_q;
        fill_tag        = fill_tag_q;
        fill_line_ix    = fill_ix_q;
        unique case (state_q)
            StIdle: ;
            StWbCmd: begin
                busy            = 1'b1;
                mem_cmd_valid   = 1'b1;
                mem_cmd_write   = 1'b1;
                mem_cmd_address = {victim_tag_q, line_addr_q[LINE_IX_BITWIDTH-1:0], 4'b0000};
            end
            StWbData: begin
                busy            = 1'b1;
                mem_wdata_valid = 1'b1;
                unique case (beat_q)
                    2'd0: mem_wdata = victim_data_q[31:0];
                    2'd1: mem_wdata = victim_data_q[63:32];
                    2'd2: mem_wdata = victim_data_q[95:64];
                    2'd3: mem_wdata = victim_data_q[127:96];
                    default: mem_wdata = 32'd0;
                endcase
            end
            StRdCmd: begin
                busy            = 1'b1;
                mem_cmd_valid   = 1'b1;
                mem_cmd_address = {line_addr_q, 4'b0000};
            end
            StRdData: begin
                busy = 1'b1;
            end
            StFill: begin
                busy       = 1'b1;
                done       = 1'b1;
                fill_write = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_line_refill.sv
module tb_cache_line_refill;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [31:0]  miss_address = '0;
    logic         victim_dirty = 1'b0;
    logic [19:0]  victim_tag = '0;
    logic [127:0] victim_data = '0;
    logic         busy, done, fill_write;
    logic [19:0]  fill_tag;
    logic [7:0]   fill_line_ix;
    logic [127:0] fill_data;
    logic         mem_cmd_valid, mem_cmd_write;
    logic [31:0]  mem_cmd_address;
    logic         mem_cmd_ready = 1'b0;
    logic [31:0]  mem_wdata;
    logic         mem_wdata_valid;
    logic         mem_wdata_ready = 1'b0;
    logic [31:0]  mem_rdata = '0;
    logic         mem_rdata_valid = 1'b0;

    cache_line_refill #(.LINE_IX_BITWIDTH(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .miss_address   (miss_address),
        .victim_dirty   (victim_dirty),
        .victim_tag     (victim_tag),
        .victim_data    (victim_data),
        .busy           (busy),
        .done           (done),
        .fill_write     (fill_write),
        .fill_tag       (fill_tag),
        .fill_line_ix   (fill_line_ix),
        .fill_data      (fill_data),
        .mem_cmd_valid  (mem_cmd_valid),
        .mem_cmd_write  (mem_cmd_write),
        .mem_cmd_address(mem_cmd_address),
        .mem_cmd_ready  (mem_cmd_ready),
        .mem_wdata      (mem_wdata),
        .mem_wdata_valid(mem_wdata_valid),
        .mem_wdata_ready(mem_wdata_ready),
        .mem_rdata      (mem_rdata),
        .mem_rdata_valid(mem_rdata_valid)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int start_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observation records filled by the monitor
    logic [31:0]  cmd_addr[$];
    logic         cmd_wr[$];
    logic [31:0]  wbeats[$];
    int           done_cnt = 0;
    int           done_rel = -1;
    int           stall_viol = 0;
    logic [127:0] fill_d = '0;
    logic [19:0]  fill_t = '0;
    logic [7:0]   fill_x = '0;
    logic         busy_at0 = 1'b0;
    logic         busy_at1 = 1'b0;
    logic         prev_cmd_stall = 1'b0;
    logic         prev_w_stall = 1'b0;
    logic [31:0]  prev_addr = '0;
    logic         prev_wr = 1'b0;
    logic [31:0]  prev_wdata = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_cmd_valid && mem_cmd_ready) begin
                cmd_addr.push_back(mem_cmd_address);
                cmd_wr.push_back(mem_cmd_write);
            end
            if (mem_wdata_valid && mem_wdata_ready) wbeats.push_back(mem_wdata);
            // A stalled command or beat must be presented unchanged on the next cycle.
            if (prev_cmd_stall && (!mem_cmd_valid || mem_cmd_address != prev_addr ||
                                   mem_cmd_write != prev_wr)) stall_viol++;
            if (prev_w_stall && (!mem_wdata_valid || mem_wdata != prev_wdata)) stall_viol++;
            prev_cmd_stall = mem_cmd_valid && !mem_cmd_ready;
            prev_w_stall   = mem_wdata_valid && !mem_wdata_ready;
            prev_addr      = mem_cmd_address;
            prev_wr        = mem_cmd_write;
            prev_wdata     = mem_wdata;
            if (cyc - start_cyc == 0) busy_at0 = busy;
            if (cyc - start_cyc == 1) busy_at1 = busy;
            if (done) begin
                done_cnt++;
                done_rel = cyc - start_cyc;
                fill_d   = fill_data;
                fill_t   = fill_tag;
                fill_x   = fill_line_ix;
            end
        end else begin
            prev_cmd_stall = 1'b0;
            prev_w_stall   = 1'b0;
        end
    end

    task automatic clear_mon();
        cmd_addr.delete();
        cmd_wr.delete();
        wbeats.delete();
        done_cnt   = 0;
        done_rel   = -1;
        stall_viol = 0;
    endtask

    // Drives one miss and acts as the memory controller. Returns mid-cycle in the FILL cycle
    // (so the next call can start on the following cycle), or right after a reset abort.
    task automatic run_miss(input logic [31:0] addr, input logic dirty, input logic [19:0] vtag,
                            input logic [127:0] vdata, input logic [31:0] rbase,
                            input int cmd_stall, input bit wtoggle, input bit rgap,
                            input bit spur, input int abort_wb);
        int waited = 0;
        bit rd_on = 0;
        bit rd_acc;
        int rcnt = 0;
        bit gap = 0;
        bit wtog = 0;
        @(posedge clk); #1;
        if (spur) begin
            mem_rdata_valid = 1'b1;
            mem_rdata = 32'hDEAD0000;
            @(posedge clk); #1;
            mem_rdata_valid = 1'b0;
        end
        start = 1'b1;
        miss_address = addr;
        victim_dirty = dirty;
        victim_tag = vtag;
        victim_data = vdata;
        start_cyc = cyc;
        @(posedge clk); #1;
        miss_address = 32'hFFFF_FFF0;
        victim_dirty = ~dirty;
        victim_tag = 20'hFFFFF;
        victim_data = {128{1'b1}};
        for (int i = 0; i < 80; i++) begin
            start = 1'b0;
            mem_rdata_valid = 1'b0;
            if (done) begin
                @(negedge clk); #1;
                mem_cmd_ready = 1'b0;
                mem_wdata_ready = 1'b0;
                return;
            end
            if (abort_wb > 0 && wbeats.size() == abort_wb) begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                mem_cmd_ready = 1'b0;
                mem_wdata_ready = 1'b0;
                return;
            end
            rd_acc = 0;
            if (mem_cmd_valid) begin
                mem_cmd_ready = (waited >= cmd_stall);
                if (mem_cmd_ready) begin
                    waited = 0;
                    rd_acc = !mem_cmd_write;
                end else begin
                    waited++;
                end
                if (spur && !mem_cmd_write) begin
                    mem_rdata_valid = 1'b1;
                    mem_rdata = 32'hBEEF0000;
                end
            end else begin
                mem_cmd_ready = 1'b0;
            end
            wtog = ~wtog;
            mem_wdata_ready = wtoggle ? wtog : 1'b1;
            if (rd_on && rcnt < 4) begin
                if (rgap && gap) begin
                    gap = 0;
                    if (spur) begin
                        start = 1'b1;
                        miss_address = 32'h0BAD_0000;
                    end
                end else begin
                    mem_rdata_valid = 1'b1;
                    mem_rdata = rbase + rcnt;
                    rcnt++;
                    gap = 1;
                end
            end
            if (rd_acc) begin
                rd_on = 1;
                rcnt = 0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        mem_rdata_valid = 1'b0;
        mem_cmd_ready = 1'b0;
        mem_wdata_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({busy, done, fill_write, mem_cmd_valid, mem_cmd_write, mem_wdata_valid} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {busy, done, fill_write, mem_cmd_valid, mem_cmd_write, mem_wdata_valid});
        end
        tests_run++;
        if (mem_cmd_address !== 32'h0 || mem_wdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_mem_buses: got %h/%h expected 0/0", mem_cmd_address, mem_wdata);
        end
        tests_run++;
        if (fill_data !== 128'h0 || fill_tag !== 20'h0 || fill_line_ix !== 8'h0) begin
            tests_failed++;
            $display("FAIL reset_fill: got %h/%h/%h expected 0", fill_data, fill_tag, fill_line_ix);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_clean_miss();
        clear_mon();
        run_miss(32'h0000_1230, 1'b0, 20'h0, 128'h0, 32'hA0, 0, 0, 0, 0, 0);
        tests_run++;
        if (cmd_addr.size() !== 1) begin
            tests_failed++;
            $display("FAIL clean_cmd_count: got %0d expected 1", cmd_addr.size());
        end else begin
            tests_run++;
            if (cmd_addr[0] !== 32'h0000_1230 || cmd_wr[0] !== 1'b0) begin
                tests_failed++;
                $display("FAIL clean_rd_cmd: got %h wr=%b expected 00001230 wr=0",
                         cmd_addr[0], cmd_wr[0]);
            end
        end
        tests_run++;
        if (fill_d !== 128'h000000A3_000000A2_000000A1_000000A0) begin
            tests_failed++;
            $display("FAIL clean_fill_data: got %h expected A3..A0", fill_d);
        end
        tests_run++;
        if (fill_t !== 20'h00001 || fill_x !== 8'h23) begin
            tests_failed++;
            $display("FAIL clean_fill_tag_ix: got %h/%h expected 00001/23", fill_t, fill_x);
        end
        tests_run++;
        if (done_rel !== 6) begin
            tests_failed++;
            $display("FAIL clean_done_cycle: got %0d expected 6", done_rel);
        end
        tests_run++;
        if (busy_at0 !== 1'b0 || busy_at1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL clean_busy_rise: got %b%b expected 01", busy_at0, busy_at1);
        end
        @(posedge clk); #1;
        tests_run++;
        if (busy !== 1'b0 || done_cnt !== 1) begin
            tests_failed++;
            $display("FAIL clean_busy_fall: got busy=%b dones=%0d expected 0/1", busy, done_cnt);
        end
    endtask

    task automatic check_dirty(input string tag, input int exp_rel);
        logic [31:0] exp_w[4] = '{32'h11, 32'h22, 32'h33, 32'h44};
        tests_run++;
        if (cmd_addr.size() !== 2) begin
            tests_failed++;
            $display("FAIL %s_cmd_count: got %0d expected 2", tag, cmd_addr.size());
        end else begin
            tests_run++;
            if (cmd_addr[0] !== 32'h0004_2230 || cmd_wr[0] !== 1'b1) begin
                tests_failed++;
                $display("FAIL %s_wb_cmd: got %h wr=%b expected 00042230 wr=1",
                         tag, cmd_addr[0], cmd_wr[0]);
            end
            tests_run++;
            if (cmd_addr[1] !== 32'h0000_1230 || cmd_wr[1] !== 1'b0) begin
                tests_failed++;
                $display("FAIL %s_rd_cmd: got %h wr=%b expected 00001230 wr=0",
                         tag, cmd_addr[1], cmd_wr[1]);
            end
        end
        tests_run++;
        if (wbeats.size() !== 4) begin
            tests_failed++;
            $display("FAIL %s_wbeat_count: got %0d expected 4", tag, wbeats.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                tests_run++;
                if (wbeats[k] !== exp_w[k]) begin
                    tests_failed++;
                    $display("FAIL %s_wbeat%0d: got %h expected %h", tag, k, wbeats[k], exp_w[k]);
                end
            end
        end
        tests_run++;
        if (fill_d !== 128'h000000B3_000000B2_000000B1_000000B0) begin
            tests_failed++;
            $display("FAIL %s_fill_data: got %h expected B3..B0", tag, fill_d);
        end
        if (exp_rel >= 0) begin
            tests_run++;
            if (done_rel !== exp_rel) begin
                tests_failed++;
                $display("FAIL %s_done_cycle: got %0d expected %0d", tag, done_rel, exp_rel);
            end
        end
        tests_run++;
        if (done_cnt !== 1 || stall_viol !== 0) begin
            tests_failed++;
            $display("FAIL %s_done_stall: got dones=%0d unstable=%0d expected 1/0",
                     tag, done_cnt, stall_viol);
        end
    endtask

    task automatic test_dirty_miss();
        clear_mon();
        run_miss(32'h0000_1230, 1'b1, 20'h00042, 128'h00000044_00000033_00000022_00000011,
                 32'hB0, 0, 0, 0, 0, 0);
        check_dirty("dirty", 11);
    endtask

    task automatic test_backpressure();
        clear_mon();
        run_miss(32'h0000_1230, 1'b1, 20'h00042, 128'h00000044_00000033_00000022_00000011,
                 32'hB0, 3, 1, 0, 0, 0);
        check_dirty("bp", -1);
    endtask

    task automatic test_spurious();
        clear_mon();
        run_miss(32'h0000_7780, 1'b0, 20'h0, 128'h0, 32'hC0, 0, 0, 1, 1, 0);
        tests_run++;
        if (fill_d !== 128'h000000C3_000000C2_000000C1_000000C0) begin
            tests_failed++;
            $display("FAIL spur_fill_data: got %h expected C3..C0", fill_d);
        end
        tests_run++;
        if (fill_t !== 20'h00007 || fill_x !== 8'h78) begin
            tests_failed++;
            $display("FAIL spur_fill_tag_ix: got %h/%h expected 00007/78", fill_t, fill_x);
        end
        repeat (5) @(posedge clk);
        #1;
        tests_run++;
        if (done_cnt !== 1 || busy !== 1'b0 || cmd_addr.size() !== 1) begin
            tests_failed++;
            $display("FAIL spur_single_op: got dones=%0d busy=%b cmds=%0d expected 1/0/1",
                     done_cnt, busy, cmd_addr.size());
        end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        run_miss(32'h0000_1230, 1'b1, 20'h00042, 128'h00000044_00000033_00000022_00000011,
                 32'hB0, 0, 0, 0, 0, 2);
        tests_run++;
        if ({busy, done, fill_write, mem_cmd_valid, mem_wdata_valid} !== 5'b0 ||
            mem_cmd_address !== 32'h0 || mem_wdata !== 32'h0 || fill_data !== 128'h0) begin
            tests_failed++;
            $display("FAIL rstmid_outputs: got flags=%b addr=%h wdata=%h fill=%h expected all 0",
                     {busy, done, fill_write, mem_cmd_valid, mem_wdata_valid},
                     mem_cmd_address, mem_wdata, fill_data);
        end
        tests_run++;
        if (wbeats.size() !== 2 || done_cnt !== 0) begin
            tests_failed++;
            $display("FAIL rstmid_abort: got beats=%0d dones=%0d expected 2/0",
                     wbeats.size(), done_cnt);
        end
        clear_mon();
        run_miss(32'h0000_9990, 1'b0, 20'h0, 128'h0, 32'hF0, 0, 0, 0, 0, 0);
        tests_run++;
        if (fill_d !== 128'h000000F3_000000F2_000000F1_000000F0 || done_rel !== 6) begin
            tests_failed++;
            $display("FAIL rstmid_restart: got fill=%h done_at=%0d expected F3..F0/6",
                     fill_d, done_rel);
        end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        run_miss(32'h0000_5670, 1'b0, 20'h0, 128'h0, 32'hD0, 0, 0, 0, 0, 0);
        tests_run++;
        if (fill_d !== 128'h000000D3_000000D2_000000D1_000000D0 || done_rel !== 6) begin
            tests_failed++;
            $display("FAIL b2b_first: got fill=%h done_at=%0d expected D3..D0/6", fill_d, done_rel);
        end
        run_miss(32'h1234_5AB0, 1'b0, 20'h0, 128'h0, 32'hE0, 0, 0, 0, 0, 0);
        tests_run++;
        if (cmd_addr.size() !== 2) begin
            tests_failed++;
            $display("FAIL b2b_cmd_count: got %0d expected 2", cmd_addr.size());
        end else begin
            tests_run++;
            if (cmd_addr[1] !== 32'h1234_5AB0) begin
                tests_failed++;
                $display("FAIL b2b_rd_cmd: got %h expected 12345AB0", cmd_addr[1]);
            end
        end
        tests_run++;
        if (fill_d !== 128'h000000E3_000000E2_000000E1_000000E0) begin
            tests_failed++;
            $display("FAIL b2b_fill_data: got %h expected E3..E0", fill_d);
        end
        tests_run++;
        if (fill_t !== 20'h12345 || fill_x !== 8'hAB || done_cnt !== 2 || done_rel !== 6) begin
            tests_failed++;
            $display("FAIL b2b_second: got tag=%h ix=%h dones=%0d at=%0d expected 12345/AB/2/6",
                     fill_t, fill_x, done_cnt, done_rel);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clean_miss();
        test_dirty_miss();
        test_backpressure();
        test_spurious();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
